mult_div_unit: RTL and testbench

Multi-cycle signed MULT/DIV engine that produces the Hi and Lo values for the datapath. It reads operands from Reg_A and Reg_B, runs a radix-2 Booth multiply or a restoring divide at one step per clock, and presents a 64-bit result on `hi`/`lo`. The result feeds the Hi/Lo registers under control of `HiLoWrite`/`DivOrM`, and from there the `MemtoReg` mux. `div_zero` feeds the controller's exception path.

---
 rtl/mult_div_unit.sv | 148 ++++++++++++++
 tb/tb_mult_div_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Signed radix-2 Booth MULT / restoring DIV; 34-cycle latency from start to done (div-by-zero: 1 cycle).
// No backpressure: start is taken only in IDLE/DONE, ignored while busy, never queued.
module mult_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] m;        // multiplicand, or |divisor|
  logic [32:0] acc;      // Booth accumulator, or partial remainder
  logic [31:0] q;        // multiplier / quotient shift register
  logic        q_m1;
  logic        sign_q;
  logic        sign_r;
  logic        op_r;
  logic        dz;

  logic        accept;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] m_ext;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [33:0] div_diff;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign a_abs  = a[31] ? (32'd0 - a) : a;
  assign b_abs  = b[31] ? (32'd0 - b) : b;
  assign m_ext  = {m[31], m};

  assign busy     = (state == S_MULT) || (state == S_DIV) || (state == S_FIX);
  assign done     = (state == S_DONE);
  assign div_zero = (state == S_DONE) && dz;

  always_comb begin
    mul_sum = acc;
    case ({q[0], q_m1})
      2'b01:   mul_sum = acc + m_ext;
      2'b10:   mul_sum = acc - m_ext;
      default: mul_sum = acc;
    endcase
    // Remainder stays below |b| <= 2^31, so acc[32] is always zero in DIV.
    div_shift = {acc[31:0], q[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, m};
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (start) begin
          if (!op)            state_nxt = S_MULT;
          else if (b == '0)   state_nxt = S_DONE;
          else                state_nxt = S_DIV;
        end
      end
      S_MULT:  if (cnt == 6'd31) state_nxt = S_FIX;
      S_DIV:   if (cnt == 6'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      m      <= '0;
      acc    <= '0;
      q      <= '0;
      q_m1   <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      op_r   <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      cnt  <= '0;
      acc  <= '0;
      q_m1 <= 1'b0;
      op_r <= op;
      dz   <= op && (b == '0);
      if (!op) begin
        m <= a;
        q <= b;
      end else begin
        m      <= b_abs;
        q      <= a_abs;
        sign_q <= a[31] ^ b[31];
        sign_r <= a[31];
      end
    end else begin
      case (state)
        S_MULT: begin
          acc  <= {mul_sum[32], mul_sum[32:1]};
          q    <= {mul_sum[0], q[31:1]};
          q_m1 <= q[0];
          cnt  <= cnt + 6'd1;
        end
        S_DIV: begin
          if (!div_diff[33]) begin
            acc <= div_diff[32:0];
            q   <= {q[30:0], 1'b1};
          end else begin
            acc <= div_shift;
            q   <= {q[30:0], 1'b0};
          end
          cnt <= cnt + 6'd1;
        end
        S_FIX: begin
          if (!op_r) begin
            hi <= acc[31:0];
            lo <= q;
          end else begin
            hi <= sign_r ? (32'd0 - acc[31:0]) : acc[31:0];
            lo <= sign_q ? (32'd0 - q) : q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: inputs driven and outputs sampled on the falling edge.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total  = 0;
  int passed = 0;
  int seen_done;

  mult_div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge just after the sampling edge E.
  task automatic start_op(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called in the cycle after E; returns in the DONE cycle (after E+33).
  task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    repeat (32) @(negedge clk);
    chk({tag, " busy_in_fix"}, busy, 1);
    chk({tag, " done_early"}, done, 0);
    @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " div_zero"}, div_zero, 0);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst div_zero", div_zero, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    rst = 1'b1;
    @(negedge clk);

    // MULT signed: 7 * -3 = -21
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    chk("mul1 busy", busy, 1);
    wait_done("mul1", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    chk("mul1 done_pulse_end", done, 0);

    // MULT extremes
    start_op(1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mul_min", 32'h4000_0000, 32'h0000_0000);
    @(negedge clk);
    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_m1", 32'h0, 32'h1);
    @(negedge clk);

    // DIV sign cases
    start_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_n7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);
    start_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_7_n2", 32'h1, 32'hFFFF_FFFD);
    @(negedge clk);
    start_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_min_m1", 32'h0, 32'h8000_0000);
    @(negedge clk);

    // Divide by zero keeps the previous hi/lo
    start_op(1'b0, 32'd3, 32'd5);
    wait_done("pre_3x5", 32'd0, 32'd15);
    @(negedge clk);
    start_op(1'b1, 32'd5, 32'd0);
    chk("dz done", done, 1);
    chk("dz div_zero", div_zero, 1);
    chk("dz busy", busy, 0);
    chk("dz hi", hi, 32'd0);
    chk("dz lo", lo, 32'd15);
    @(negedge clk);
    chk("dz done_end", done, 0);
    chk("dz div_zero_end", div_zero, 0);
    chk("dz busy_after", busy, 0);

    // start during iteration 10 is ignored
    start_op(1'b0, 32'h1234_5678, 32'h10);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (22) @(negedge clk);
    chk("ign done_early", done, 0);
    @(negedge clk);
    chk("ign done", done, 1);
    chk("ign hi", hi, 32'h1);
    chk("ign lo", lo, 32'h2345_6780);

    // Back-to-back: start in the DONE cycle
    start_op(1'b1, 32'd100, 32'd7);
    chk("b2b busy", busy, 1);
    chk("b2b done_dropped", done, 0);
    wait_done("b2b", 32'd2, 32'd14);
    @(negedge clk);

    // Reset during MULT iteration 20, with start on the same edge
    start_op(1'b0, 32'd7, 32'hFFFF_FFFD);
    repeat (19) @(negedge clk);
    chk("pre_rst busy", busy, 1);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst hi", hi, 0);
    chk("mid_rst lo", lo, 0);
    rst   = 1'b1;
    start = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen_done++;
    end
    chk("post_rst no_activity", seen_done, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
